// File: rtl/resonator_scheduler.sv
// Resonator bank that shares one signed multiplier across all voices. On each 48 kHz tick
// every voice is stepped in turn, then the voices are mixed into one offset-binary sample.
module resonator_scheduler #(
    parameter int          VOICES       = 4,
    parameter logic [23:0] COS_DEFAULT  = 24'd2096930,
    parameter logic [23:0] DAMP_DEFAULT = 24'd1047939
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_48KHz_en,
    input  logic [4*VOICES-1:0]   kick,
    input  logic                  cfg_we,
    input  logic [3:0]            cfg_addr,
    input  logic [23:0]           cfg_data,
    input  logic [VOICES-1:0]     mute,
    output logic [15:0]           out,
    output logic                  busy,
    output logic                  overrun
);
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [VW-1:0] LAST_V = VW'(VOICES - 1);
    localparam logic signed [27:0] CLAMP_LIM = -28'sd16777216;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LOAD    = 3'd1;
    localparam logic [2:0] MUL_P   = 3'd2;
    localparam logic [2:0] MUL_OSC = 3'd3;
    localparam logic [2:0] MUL_D   = 3'd4;
    localparam logic [2:0] MIX     = 3'd5;

    logic [2:0]         state_reg;
    logic [VW-1:0]      v_reg;
    logic [23:0]        k_reg;
    logic [23:0]        d_reg;
    logic signed [27:0] delta_reg;
    logic signed [27:0] pre_reg;
    logic [15:0]        out_reg;
    logic               overrun_reg;

    logic signed [27:0] c_reg [VOICES];
    logic signed [27:0] l_reg [VOICES];
    logic signed [27:0] p_reg [VOICES];
    logic [3:0]         last_kick_reg [VOICES];
    logic [23:0]        cos_reg [VOICES];
    logic [23:0]        damp_reg [VOICES];

    logic [3:0]         kick_v [VOICES];
    logic signed [15:0] s_v [VOICES];

    genvar gi;
    generate
        for (gi = 0; gi < VOICES; gi++) begin : g_voice
            assign kick_v[gi] = kick[4*gi +: 4];
            // Below -2^24 the voice is pinned at the -4096 floor before mixing.
            assign s_v[gi] = mute[gi] ? 16'sd0 :
                             ((c_reg[gi] < CLAMP_LIM) ? -16'sd4096 : c_reg[gi][27:12]);
        end
    endgenerate

    logic [4:0]         kick_diff;
    logic signed [27:0] delta_calc;
    assign kick_diff  = {1'b0, last_kick_reg[v_reg]} - {1'b0, kick_v[v_reg]};
    assign delta_calc = {{6{kick_diff[4]}}, kick_diff, 17'd0};

    // The single shared multiplier: operands steered by the sequencer state.
    logic signed [27:0] mul_a;
    logic [23:0]        mul_b;
    logic signed [52:0] product;
    logic signed [27:0] mul_scaled;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_reg)
            MUL_P: begin
                mul_a = l_reg[v_reg];
                mul_b = d_reg;
            end
            MUL_OSC: begin
                mul_a = c_reg[v_reg];
                mul_b = k_reg;
            end
            MUL_D: begin
                mul_a = pre_reg;
                mul_b = d_reg;
            end
            default: ;
        endcase
    end

    assign product    = 53'(mul_a) * 53'($signed({1'b0, mul_b}));
    assign mul_scaled = 28'(product >>> 20);

    logic signed [19:0] mix_sum;
    logic signed [15:0] mix_sat;

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < VOICES; i++) begin
            mix_sum = mix_sum + 20'(s_v[i]);
        end
        if (mix_sum > 20'sd32767) begin
            mix_sat = 16'sh7FFF;
        end else if (mix_sum < -20'sd32768) begin
            mix_sat = 16'sh8000;
        end else begin
            mix_sat = mix_sum[15:0];
        end
    end

    logic [2:0] cfg_voice;
    logic       cfg_hit;
    assign cfg_voice = cfg_addr[3:1];
    assign cfg_hit   = cfg_we && (32'(cfg_voice) < VOICES);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            v_reg       <= '0;
            k_reg       <= '0;
            d_reg       <= '0;
            delta_reg   <= '0;
            pre_reg     <= '0;
            out_reg     <= 16'h8000;
            overrun_reg <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                c_reg[i]         <= '0;
                l_reg[i]         <= '0;
                p_reg[i]         <= '0;
                last_kick_reg[i] <= '0;
                cos_reg[i]       <= COS_DEFAULT;
                damp_reg[i]      <= DAMP_DEFAULT;
            end
        end else begin
            if (cfg_hit) begin
                if (cfg_addr[0]) begin
                    damp_reg[cfg_voice[VW-1:0]] <= cfg_data;
                end else begin
                    cos_reg[cfg_voice[VW-1:0]] <= cfg_data;
                end
            end

            if (clk_48KHz_en && (state_reg != IDLE)) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (clk_48KHz_en) begin
                        state_reg <= LOAD;
                        v_reg     <= '0;
                    end
                end
                LOAD: begin
                    k_reg                <= cos_reg[v_reg];
                    d_reg                <= damp_reg[v_reg];
                    delta_reg            <= delta_calc;
                    last_kick_reg[v_reg] <= kick_v[v_reg];
                    state_reg            <= MUL_P;
                end
                MUL_P: begin
                    p_reg[v_reg] <= mul_scaled;
                    state_reg    <= MUL_OSC;
                end
                MUL_OSC: begin
                    // p_reg already holds this tick's D(l).
                    pre_reg      <= delta_reg + mul_scaled - p_reg[v_reg];
                    l_reg[v_reg] <= c_reg[v_reg];
                    state_reg    <= MUL_D;
                end
                MUL_D: begin
                    c_reg[v_reg] <= mul_scaled;
                    if (v_reg == LAST_V) begin
                        state_reg <= MIX;
                    end else begin
                        v_reg     <= v_reg + VW'(1);
                        state_reg <= LOAD;
                    end
                end
                MIX: begin
                    out_reg   <= {~mix_sat[15], mix_sat[14:0]};
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out     = out_reg;
    assign busy    = (state_reg != IDLE);
    assign overrun = overrun_reg;

endmodule

// File: tb/tb_resonator_scheduler.sv
// Directed and randomized bench for resonator_scheduler, checked against a per-tick
// arithmetic model of the resonator recurrence and the mixer.
module tb_resonator_scheduler;
    localparam int    VOICES   = 4;
    localparam longint CLAMP   = -16777216;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 clk_48KHz_en;
    logic [4*VOICES-1:0]  kick;
    logic                 cfg_we;
    logic [3:0]           cfg_addr;
    logic [23:0]          cfg_data;
    logic [VOICES-1:0]    mute;
    logic [15:0]          out;
    logic                 busy;
    logic                 overrun;

    resonator_scheduler #(
        .VOICES      (VOICES),
        .COS_DEFAULT (24'd2096930),
        .DAMP_DEFAULT(24'd1047939)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_48KHz_en(clk_48KHz_en),
        .kick        (kick),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .mute        (mute),
        .out         (out),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int vec_count   = 0;
    int miscompares = 0;
    int tick_no     = 0;

    longint     m_c    [VOICES];
    longint     m_l    [VOICES];
    longint     m_p    [VOICES];
    longint     m_cos  [VOICES];
    longint     m_damp [VOICES];
    int         m_lk   [VOICES];
    logic [15:0] m_out;
    bit         m_ovr;
    longint     m_sum;

    task automatic check_val(input string tag, input longint got, input longint exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic longint t28(input longint x);
        logic [27:0] b;
        b = x[27:0];
        return longint'($signed(b));
    endfunction

    function automatic longint damp_mul(input longint x, input longint d);
        return t28((x * d) >>> 20);
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VOICES; v++) begin
            m_c[v] = 0; m_l[v] = 0; m_p[v] = 0; m_lk[v] = 0;
            m_cos[v] = 2096930; m_damp[v] = 1047939;
        end
        m_out = 16'h8000;
        m_ovr = 1'b0;
        m_sum = 0;
    endtask

    // One full tick: every voice stepped with the coefficients in force at its LOAD.
    task automatic model_tick(input int wr_off, input logic [3:0] wr_addr,
                              input logic [23:0] wr_data, input int ovr_off);
        int wv, kv;
        longint k, d, delta, pnew, pre, s, sum;
        wv = int'(wr_addr[3:1]);
        for (int v = 0; v < VOICES; v++) begin
            k = m_cos[v];
            d = m_damp[v];
            if (wr_off >= 0 && wv == v && wr_off <= 4*v) begin
                if (wr_addr[0]) d = longint'(wr_data);
                else            k = longint'(wr_data);
            end
            kv    = int'(kick[4*v +: 4]);
            delta = longint'(m_lk[v] - kv) * 131072;
            pnew  = damp_mul(m_l[v], d);
            pre   = t28(delta + t28((k * m_c[v]) >>> 20) - pnew);
            m_p[v]  = pnew;
            m_l[v]  = m_c[v];
            m_c[v]  = damp_mul(pre, d);
            m_lk[v] = kv;
        end
        if (wr_off >= 0 && wv < VOICES) begin
            if (wr_addr[0]) m_damp[wv] = longint'(wr_data);
            else            m_cos[wv]  = longint'(wr_data);
        end
        if (ovr_off > 0 && ovr_off < 18) m_ovr = 1'b1;
        sum = 0;
        for (int v = 0; v < VOICES; v++) begin
            if (!mute[v]) begin
                s = (m_c[v] < CLAMP) ? -4096 : (m_c[v] >>> 12);
                sum += s;
            end
        end
        m_sum = sum;
        if (sum > 32767)  sum = 32767;
        if (sum < -32768) sum = -32768;
        m_out = 16'(sum + 32768);
    endtask

    task automatic do_reset();
        clk_48KHz_en = 1'b0;
        cfg_we = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [23:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (int'(addr[3:1]) < VOICES) begin
            if (addr[0]) m_damp[addr[3:1]] = longint'(data);
            else         m_cos[addr[3:1]]  = longint'(data);
        end
    endtask

    // Tick raised in cycle 0; optional config write in cycle wr_off, extra tick in ovr_off.
    task automatic do_tick(input int wr_off, input logic [3:0] wr_addr,
                           input logic [23:0] wr_data, input int ovr_off);
        logic [15:0] prev_out;
        prev_out = m_out;
        model_tick(wr_off, wr_addr, wr_data, ovr_off);
        for (int t = 0; t < 18; t++) begin
            clk_48KHz_en = (t == 0) || (t == ovr_off);
            if (t == wr_off) begin
                cfg_we = 1'b1; cfg_addr = wr_addr; cfg_data = wr_data;
            end
            if (t == 17) begin
                check_val("out_hold", out, prev_out);
                check_val("busy_mid", busy, 1);
            end
            @(posedge clk); #1;
            clk_48KHz_en = 1'b0;
            cfg_we = 1'b0;
        end
        check_val("out", out, m_out);
        check_val("busy_end", busy, 0);
        check_val("overrun", overrun, m_ovr);
        $display("tick %0d: kick=0x%04h mute=%b out=0x%04h model=0x%04h",
                 tick_no, kick, mute, out, m_out);
        tick_no++;
    endtask

    initial begin
        int wr_off, ovr_off;
        logic [3:0] wa;
        logic [23:0] wd;

        reset = 1'b1; clk_48KHz_en = 1'b0; kick = '0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; mute = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_val("rst_out", out, 16'h8000);
        check_val("rst_busy", busy, 0);
        check_val("rst_overrun", overrun, 0);

        // Abort a sequence with reset 7 cycles after the tick.
        kick = 16'h000F;
        for (int t = 0; t < 7; t++) begin
            clk_48KHz_en = (t == 0) || (t == 3);
            @(posedge clk); #1;
        end
        clk_48KHz_en = 1'b0;
        check_val("pre_abort_overrun", overrun, 1);
        check_val("pre_abort_busy", busy, 1);
        reset = 1'b1;
        #1;
        check_val("abort_out", out, 16'h8000);
        check_val("abort_busy", busy, 0);
        check_val("abort_overrun", overrun, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        repeat (20) @(posedge clk);
        #1 check_val("abort_no_update", out, 16'h8000);

        // Single kick on voice 0, then a free-running decay with kick held.
        do_tick(-1, 4'h0, 24'd0, -1);
        check_val("kick_first", out, 16'h7E20);
        for (int n = 0; n < 20; n++) do_tick(-1, 4'h0, 24'd0, -1);

        // Clamp: undamped quarter-rate resonator on voice 0 grows past -2^24.
        do_reset();
        kick = '0;
        cfg_write(4'h0, 24'd0);
        cfg_write(4'h1, 24'h100000);
        for (int n = 0; n < 20; n++) begin
            if (n % 4 == 0) kick = 16'h000F;
            else if (n % 4 == 2) kick = 16'h0000;
            do_tick(-1, 4'h0, 24'd0, -1);
            if (m_c[0] < CLAMP) check_val("clamp", out, 16'h7000);
        end

        // Saturation: all voices driven the same way until the mix exceeds full scale.
        do_reset();
        kick = '0;
        for (int v = 0; v < VOICES; v++) begin
            cfg_write({3'(v), 1'b0}, 24'd0);
            cfg_write({3'(v), 1'b1}, 24'h100000);
        end
        for (int n = 0; n < 36; n++) begin
            if (n % 4 == 0) kick = 16'hFFFF;
            else if (n % 4 == 2) kick = 16'h0000;
            do_tick(-1, 4'h0, 24'd0, -1);
            if (m_sum > 32767) check_val("saturate", out, 16'hFFFF);
        end

        // Overrun: second tick 5 cycles in is ignored but sticky.
        do_reset();
        kick = 16'h5A3C;
        do_tick(-1, 4'h0, 24'd0, 5);
        repeat (20) @(posedge clk);
        #1;
        check_val("ovr_no_extra_out", out, m_out);
        check_val("ovr_idle", busy, 0);
        check_val("ovr_sticky", overrun, 1);

        // Config write timing relative to each voice's LOAD.
        do_reset();
        kick = 16'hFFFF;
        do_tick(-1, 4'h0, 24'd0, -1);
        do_tick(7, 4'h4, 24'd2000000, -1);
        do_tick(9, 4'h4, 24'd1500000, -1);
        do_tick(-1, 4'h0, 24'd0, -1);
        do_tick(3, 4'hA, 24'd100, -1);
        do_tick(2, 4'h7, 24'd900000, -1);
        do_tick(-1, 4'h0, 24'd0, -1);

        // Mute excludes an active voice from the mix only.
        do_reset();
        kick = 16'h00F0;
        mute = 4'b0010;
        do_tick(-1, 4'h0, 24'd0, -1);
        check_val("mute_out", out, 16'h8000);
        mute = 4'b0000;
        do_tick(-1, 4'h0, 24'd0, -1);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 30; n++) begin
            kick = 16'($urandom);
            mute = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                wa = 4'($urandom);
                wd = wa[0] ? 24'($urandom_range(900000, 1048576))
                           : 24'($urandom_range(1800000, 2097151));
                cfg_write(wa, wd);
            end
            wa = 4'($urandom);
            wd = wa[0] ? 24'($urandom_range(900000, 1048576))
                       : 24'($urandom_range(1800000, 2097151));
            wr_off  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 17)) : -1;
            ovr_off = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 17)) : -1;
            do_tick(wr_off, wa, wd, ovr_off);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
